// File: rtl/signed_divider.sv
// Signed 8-bit / 4-bit restoring divider: an 8-step unsigned magnitude divide, then sign fix-up.
// DIV_SATURATE_EN: when defined, the -128 / -1 quotient saturates to +127 instead of wrapping to -128.
module signed_divider (
  input  logic       clock,
  input  logic       reset,
  input  logic       strt,
  input  logic [7:0] N,
  input  logic [3:0] D,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       done,
  output logic       busy,
  output logic       dz,
  output logic       ovf,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;     // dividend magnitude, shifts out MSB first, quotient shifts in
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] rem_q, rem_d;
  logic       sn_q, sn_d, sd_q, sd_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] res_r_q, res_r_d;
  logic       dz_q, dz_d, ovf_q, ovf_d;

  logic       load;
  logic [4:0] shifted;
  logic       ge;
  logic       neg;
  logic [7:0] q_signed, q_final;
  logic [3:0] r_signed;
  logic       ovf_hit;

  assign load = strt && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      res_r_q <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      res_r_q <= res_r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (strt) state_d = (D == 4'd0) ? S_DONE : S_CALC;
      S_CALC:         if (cnt_q == 4'd1) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done      = (state_q == S_DONE);
    busy      = (state_q == S_CALC) || (state_q == S_FIX);
    state_dbg = state_q;
  end

  // Only -128 / -1 yields a positive quotient magnitude with bit 7 set.
  always_comb begin
    shifted  = {rem_q, dvd_q[7]};
    ge       = (shifted >= {1'b0, dvs_q});
    neg      = sn_q ^ sd_q;
    q_signed = neg ? (8'd0 - dvd_q) : dvd_q;
    r_signed = sn_q ? (4'd0 - rem_q) : rem_q;
    ovf_hit  = !neg && dvd_q[7];
`ifdef DIV_SATURATE_EN
    q_final  = ovf_hit ? 8'h7F : q_signed;
`else
    q_final  = q_signed;
`endif
  end

  always_comb begin
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    res_r_d = res_r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    if (load) begin
      dz_d  = (D == 4'd0);
      ovf_d = 1'b0;
      if (D == 4'd0) begin
        quo_d   = '0;
        res_r_d = '0;
      end else begin
        dvd_d = N[7] ? (8'd0 - N) : N;
        dvs_d = D[3] ? (4'd0 - D) : D;
        sn_d  = N[7];
        sd_d  = D[3];
        rem_d = '0;
        cnt_d = 4'd8;
      end
    end else if (state_q == S_CALC) begin
      rem_d = ge ? 4'(shifted - {1'b0, dvs_q}) : shifted[3:0];
      dvd_d = {dvd_q[6:0], ge};
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == S_FIX) begin
      quo_d   = q_final;
      res_r_d = r_signed;
      ovf_d   = ovf_hit;
      dz_d    = 1'b0;
    end
  end

  assign Q   = quo_q;
  assign R   = res_r_q;
  assign dz  = dz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider: hand-computed quotient/remainder vectors, latency, reset abort, restart.
module tb_signed_divider;
  logic       clock = 1'b0;
  logic       reset;
  logic       strt;
  logic [7:0] N;
  logic [3:0] D;
  logic [7:0] Q;
  logic [3:0] R;
  logic       done, busy, dz, ovf;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  signed_divider dut (
    .clock(clock), .reset(reset), .strt(strt), .N(N), .D(D),
    .Q(Q), .R(R), .done(done), .busy(busy), .dz(dz), .ovf(ovf),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses strt for one edge, scrambles N/D after the load edge, waits (bounded) for done.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, output int lat, output logic busy_seen);
    @(negedge clock);
    N = n; D = d; strt = 1'b1;
    @(negedge clock);
    strt = 1'b0; N = 8'h00; D = 4'h0;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      busy_seen |= busy;
    end
  endtask

  task automatic div_case(input string tag, input logic [7:0] n, input logic [3:0] d,
                          input int exp_lat, input logic [7:0] eq, input logic [3:0] er,
                          input logic edz, input logic eovf);
    int   lat;
    logic bs;
    run_op(n, d, lat, bs);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"}, Q, eq);
    check({tag, ".r"}, R, er);
    check({tag, ".dz"}, dz, edz);
    check({tag, ".ovf"}, ovf, eovf);
    check({tag, ".busy_seen"}, bs, (exp_lat != 1));
  endtask

  logic [7:0] ovf_q_exp;
  int         lat, lowcnt;

  initial begin
`ifdef DIV_SATURATE_EN
    ovf_q_exp = 8'h7F;
`else
    ovf_q_exp = 8'h80;
`endif
    reset = 1'b1; strt = 1'b0; N = 8'h00; D = 4'h0;
    repeat (2) @(negedge clock);
    check("rst.done", done, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.q", Q, 8'h00);
    check("rst.r", R, 4'h0);
    check("rst.state", state_dbg, 2'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_hold.state", state_dbg, 2'd0);
    check("idle_hold.done", done, 1'b0);

    div_case("m21_m3", 8'hEB, 4'hD, 10, 8'h07, 4'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    check("hold.q", Q, 8'h07);
    check("hold.done", done, 1'b1);

    div_case("p23_m5", 8'h17, 4'hB, 10, 8'hFC, 4'h3, 1'b0, 1'b0);
    div_case("m23_p5", 8'hE9, 4'h5, 10, 8'hFC, 4'hD, 1'b0, 1'b0);
    div_case("divzero", 8'h55, 4'h0, 1, 8'h00, 4'h0, 1'b1, 1'b0);
    div_case("p127_m8", 8'h7F, 4'h8, 10, 8'hF1, 4'h7, 1'b0, 1'b0);
    div_case("m128_p7", 8'h80, 4'h7, 10, 8'hEE, 4'hE, 1'b0, 1'b0);
    div_case("overflow", 8'h80, 4'hF, 10, ovf_q_exp, 4'h0, 1'b0, 1'b1);

    // Abort a 100/7 run after edge 5.
    @(negedge clock);
    N = 8'h64; D = 4'h7; strt = 1'b1;
    @(negedge clock);
    strt = 1'b0;
    repeat (4) @(negedge clock);
    check("abort.busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort.done", done, 1'b0);
    check("abort.busy", busy, 1'b0);
    check("abort.q", Q, 8'h00);
    check("abort.r", R, 4'h0);
    check("abort.dz", dz, 1'b0);
    check("abort.ovf", ovf, 1'b0);
    check("abort.state", state_dbg, 2'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("abort.idle", state_dbg, 2'd0);
    div_case("p100_p7", 8'h64, 4'h7, 10, 8'h0E, 4'h2, 1'b0, 1'b0);
    div_case("dz_from_done", 8'h55, 4'h0, 1, 8'h00, 4'h0, 1'b1, 1'b0);

    // strt held high through CALC/FIX, then restarts straight out of DONE.
    @(negedge clock);
    N = 8'h64; D = 4'h7; strt = 1'b1;
    @(negedge clock);
    N = 8'h7F; D = 4'h2;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("held.lat", lat, 10);
    check("held.q", Q, 8'h0E);
    check("held.r", R, 4'h2);
    @(negedge clock);
    check("b2b.done_drop", done, 1'b0);
    strt = 1'b0; N = 8'h00; D = 4'h0;
    lowcnt = 0;
    while (!done && lowcnt < 40) begin
      lowcnt++;
      @(negedge clock);
    end
    check("b2b.low_edges", lowcnt, 9);
    check("b2b.q", Q, 8'h3F);
    check("b2b.r", R, 4'h1);
    check("b2b.dz", dz, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
